// File: rtl/wb_stage.sv
// MangoMIPS32 write-back stage: load alignment/extension, GPR write port, HI/LO and LLbit state.
// Optional debug trace port and retired-instruction counter enabled by defining WB_DEBUG_TRACE_EN.
module wb_stage #(
    parameter logic [63:0] HILO_RST = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        exc_llb_clr,
    input  logic [31:0] wb_pc,
    input  logic [7:0]  wb_aluop,
    input  logic [31:0] wb_alures,
    input  logic [31:0] wb_m_vaddr,
    input  logic [31:0] wb_m_rdata,
    input  logic [3:0]  wb_wreg,
    input  logic [4:0]  wb_wraddr,
    input  logic        wb_hilo_wen,
    input  logic [63:0] wb_hilo,
    input  logic        wb_llb_wen,
    input  logic        wb_llbit,
    output logic [3:0]  rf_wen,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        llbit_o
`ifdef WB_DEBUG_TRACE_EN
    ,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic [31:0] debug_wb_instret
`endif
);

    // Op codes mirror the ALU_* values of the shared pipeline defines header.
    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_LB  = 8'h20;
    localparam logic [7:0] ALU_LBU = 8'h21;
    localparam logic [7:0] ALU_LH  = 8'h22;
    localparam logic [7:0] ALU_LHU = 8'h23;
    localparam logic [7:0] ALU_LW  = 8'h24;
    localparam logic [7:0] ALU_LL  = 8'h25;
    localparam logic [7:0] ALU_LWL = 8'h26;
    localparam logic [7:0] ALU_LWR = 8'h27;

    logic [1:0]  offset;
    logic [1:0]  lwlShift;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;
    logic [31:0] ldData;
    logic [3:0]  wenMask;

    assign offset   = wb_m_vaddr[1:0];
    assign lwlShift = 2'd3 - offset;
    assign ldByte   = wb_m_rdata[{offset, 3'b000} +: 8];
    assign ldHalf   = wb_m_rdata[{wb_m_vaddr[1], 4'b0000} +: 16];

    always_comb begin
        ldData  = wb_alures;
        wenMask = 4'hF;
        case (wb_aluop)
            ALU_LB:  ldData = {{24{ldByte[7]}}, ldByte};
            ALU_LBU: ldData = {24'h0, ldByte};
            ALU_LH:  ldData = {{16{ldHalf[15]}}, ldHalf};
            ALU_LHU: ldData = {16'h0, ldHalf};
            ALU_LW,
            ALU_LL:  ldData = wb_m_rdata;
            ALU_LWL: begin
                ldData  = wb_m_rdata << {lwlShift, 3'b000};
                wenMask = 4'hF << lwlShift;
            end
            ALU_LWR: begin
                ldData  = wb_m_rdata >> {offset, 3'b000};
                wenMask = 4'hF >> offset;
            end
            default: ;
        endcase
    end

    // r0 is hardwired zero, so writes to it are dropped here rather than in the regfile.
    always_comb begin
        rf_wen   = 4'h0;
        rf_wdata = 32'h0;
        if (!rst) begin
            rf_wdata = ldData;
            if (!stall && (wb_wraddr != 5'd0))
                rf_wen = wb_wreg & wenMask;
        end
    end

    assign rf_waddr = wb_wraddr;

    logic        hiloWrite;
    logic [31:0] hi_q, lo_q;
    logic [63:0] hilo_d;
    logic        llbit_q, llbit_d;

    assign hiloWrite = wb_hilo_wen & ~stall;

    always_comb begin
        hilo_d = {hi_q, lo_q};
        if (hiloWrite)
            hilo_d = wb_hilo;
    end

    // An exception commit clears LLbit even when the stage is stalled.
    always_comb begin
        llbit_d = llbit_q;
        if (exc_llb_clr)
            llbit_d = 1'b0;
        else if (wb_llb_wen && !stall)
            llbit_d = wb_llbit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {hi_q, lo_q} <= HILO_RST;
            llbit_q      <= 1'b0;
        end else begin
            {hi_q, lo_q} <= hilo_d;
            llbit_q      <= llbit_d;
        end
    end

    assign hi_o    = hilo_d[63:32];
    assign lo_o    = hilo_d[31:0];
    assign llbit_o = llbit_d;

`ifdef WB_DEBUG_TRACE_EN
    logic [31:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (!stall && (wb_aluop != ALU_NOP))
            instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            instret_q <= 32'h0;
        else
            instret_q <= instret_d;
    end

    assign debug_wb_pc       = wb_pc;
    assign debug_wb_rf_wen   = rf_wen;
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;
    assign debug_wb_instret  = instret_q;

    logic unused_vaddr;
    assign unused_vaddr = ^wb_m_vaddr[31:2];
`else
    logic unused_vaddr;
    assign unused_vaddr = ^{wb_m_vaddr[31:2], wb_pc};
`endif

endmodule
